add12u_err_monitor: RTL and testbench

// - Streaming consumer for the add12u approximate adders: takes (A, B, O) triples

---
 rtl/add12u_err_monitor.sv | 150 +++++++++++++++
 tb/tb_add12u_err_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/add12u_err_monitor.sv
// Error-metric accumulator for add12u approximate adders: consumes (A, B, O) triples
// and tracks sample count, error count, sum of absolute error and worst-case error.
module add12u_err_monitor #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH:0]       in_o,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     sae,
    output logic [WIDTH:0]       wce,
    output logic                 sat
);

    localparam int unsigned OW    = WIDTH + 1;
    localparam int unsigned DW    = WIDTH + 2;
    // Wide enough that neither accumulator operand can wrap before the saturation check.
    localparam int unsigned SUM_W = ((CNT_W > OW) ? CNT_W : OW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;
    logic   clear_c;
    logic   accept_c;

    logic          s1_valid;
    logic [OW-1:0] s1_err;

    logic [OW-1:0]        exact_c;
    logic signed [DW-1:0] diff_c;
    logic [OW-1:0]        err_c;

    logic [SUM_W-1:0] smp_sum_c;
    logic [SUM_W-1:0] err_sum_c;
    logic [SUM_W-1:0] sae_sum_c;
    logic             smp_ovf_c;
    logic             err_ovf_c;
    logic             sae_ovf_c;

    assign in_ready = (state == S_RUN);
    assign accept_c = in_valid & in_ready;

    // Next-state logic; DRAIN waits until the final sample has left stage 1.
    always_comb begin
        state_nxt = state;
        clear_c   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    clear_c   = 1'b1;
                end
            end
            S_RUN: begin
                if (accept_c && in_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!s1_valid) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage 1: exact sum and absolute error, signed on DW bits so nothing wraps.
    always_comb begin
        exact_c = OW'(in_a) + OW'(in_b);
        diff_c  = $signed({1'b0, exact_c}) - $signed({1'b0, in_o});
        if (diff_c[DW-1]) begin
            err_c = OW'(-diff_c);
        end else begin
            err_c = OW'(diff_c);
        end
    end

    // Stage 2 arithmetic with overflow detection for the saturating accumulators.
    always_comb begin
        smp_sum_c = SUM_W'(sample_cnt) + SUM_W'(1);
        err_sum_c = SUM_W'(err_cnt) + SUM_W'(s1_err != '0);
        sae_sum_c = SUM_W'(sae) + SUM_W'(s1_err);
        smp_ovf_c = (smp_sum_c > SUM_W'(CNT_MAX));
        err_ovf_c = (err_sum_c > SUM_W'(CNT_MAX));
        sae_ovf_c = (sae_sum_c > SUM_W'(CNT_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            s1_valid <= 1'b0;
            s1_err   <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            done     <= (state_nxt == S_DONE);
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_err <= err_c;
            end
        end
    end

    // Metric accumulators: cleared by start, updated once per stage-1 sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sae        <= '0;
            wce        <= '0;
            sat        <= 1'b0;
        end else if (clear_c) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sae        <= '0;
            wce        <= '0;
            sat        <= 1'b0;
        end else if (s1_valid) begin
            sample_cnt <= smp_ovf_c ? CNT_MAX : CNT_W'(smp_sum_c);
            err_cnt    <= err_ovf_c ? CNT_MAX : CNT_W'(err_sum_c);
            sae        <= sae_ovf_c ? CNT_MAX : CNT_W'(sae_sum_c);
            if (s1_err > wce) begin
                wce <= s1_err;
            end
            if (smp_ovf_c || err_ovf_c || sae_ovf_c) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_add12u_err_monitor.sv
// Directed testbench for add12u_err_monitor using add12u_074 reference triples.
module tb_add12u_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic [11:0] in_a;
    logic [11:0] in_b;
    logic [12:0] in_o;

    logic        in_ready, busy, done, sat;
    logic [23:0] sample_cnt, err_cnt, sae;
    logic [12:0] wce;

    logic        in_ready4, busy4, done4, sat4;
    logic [3:0]  sample_cnt4, err_cnt4, sae4;
    logic [12:0] wce4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    add12u_err_monitor dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_a(in_a), .in_b(in_b), .in_o(in_o), .busy(busy), .done(done),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sae(sae), .wce(wce), .sat(sat)
    );

    add12u_err_monitor #(.WIDTH(12), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
        .in_last(in_last), .in_a(in_a), .in_b(in_b), .in_o(in_o), .busy(busy4), .done(done4),
        .sample_cnt(sample_cnt4), .err_cnt(err_cnt4), .sae(sae4), .wce(wce4), .sat(sat4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_metrics(input string tag, input int s, input int e, input int sa, input int w);
        chk({tag, "_smp"}, 32'(sample_cnt), 32'(s));
        chk({tag, "_err"}, 32'(err_cnt), 32'(e));
        chk({tag, "_sae"}, 32'(sae), 32'(sa));
        chk({tag, "_wce"}, 32'(wce), 32'(w));
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [12:0] o,
                        input logic last);
        in_a     = a;
        in_b     = b;
        in_o     = o;
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; in_o = '0;
        tick();
        tick();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk_metrics("rst", 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // T1: back-to-back stream, done exactly two cycles after the last accept
        do_start();
        chk("t1_ready", 32'(in_ready), 32'd1);
        send(12'd3, 12'd0, 13'd4, 1'b0);
        send(12'd0, 12'd3, 13'd3, 1'b0);
        send(12'd2, 12'd2, 13'd6, 1'b1);
        chk("t1_drain_busy", 32'(busy), 32'd1);
        chk("t1_drain_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t1_e1_done", 32'(done), 32'd0);
        tick();
        chk("t1_e2_done", 32'(done), 32'd1);
        chk("t1_e2_busy", 32'(busy), 32'd0);
        chk_metrics("t1", 3, 2, 3, 2);
        chk("t1_sat", 32'(sat), 32'd0);
        tick();
        tick();
        chk("t1_hold", 32'(sample_cnt), 32'd3);

        // T2: triples offered in IDLE are dropped
        do_reset();
        in_a = 12'd1; in_b = 12'd1; in_o = 13'd1; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_idle_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk_metrics("t2_idle", 0, 0, 0, 0);
        chk("t2_idle_busy", 32'(busy), 32'd0);
        do_start();
        send(12'd1, 12'd1, 13'd1, 1'b1);
        wait_done("t2");
        chk_metrics("t2", 1, 1, 1, 1);

        // T3: exact results and full-range error
        do_start();
        send(12'h7FF, 12'h001, 13'h0800, 1'b0);
        send(12'hFFF, 12'hFFF, 13'h1FFE, 1'b1);
        wait_done("t3a");
        chk_metrics("t3a", 2, 0, 0, 0);
        do_start();
        send(12'h000, 12'h000, 13'h1FFF, 1'b1);
        wait_done("t3b");
        chk_metrics("t3b", 1, 1, 13'h1FFF, 13'h1FFF);
        chk("t3b_sat", 32'(sat), 32'd0);

        // T4: saturation on the 4-bit instance
        do_start();
        for (int i = 0; i < 17; i++) begin
            send(12'd1, 12'd1, 13'd1, (i == 16));
        end
        wait_done("t4");
        chk("t4_smp4", 32'(sample_cnt4), 32'd15);
        chk("t4_err4", 32'(err_cnt4), 32'd15);
        chk("t4_sae4", 32'(sae4), 32'd15);
        chk("t4_wce4", 32'(wce4), 32'd1);
        chk("t4_sat4", 32'(sat4), 32'd1);
        chk("t4_done4", 32'(done4), 32'd1);
        chk("t4_smp", 32'(sample_cnt), 32'd17);
        chk("t4_sat", 32'(sat), 32'd0);

        // T5: asynchronous reset mid-run
        do_start();
        send(12'd3, 12'd0, 13'd4, 1'b0);
        send(12'd0, 12'd3, 13'd3, 1'b0);
        chk("t5_pre_smp", 32'(sample_cnt), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", 32'(in_ready), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk_metrics("t5_rst", 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("t5_post_smp", 32'(sample_cnt), 32'd0);
        chk("t5_post_ready", 32'(in_ready), 32'd0);
        do_start();
        send(12'd3, 12'd0, 13'd4, 1'b1);
        wait_done("t5");
        chk_metrics("t5", 1, 1, 1, 1);

        // T6: start ignored in RUN/DRAIN, honoured in DONE
        do_start();
        send(12'd3, 12'd0, 13'd4, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_run_busy", 32'(busy), 32'd1);
        chk("t6_run_smp", 32'(sample_cnt), 32'd1);
        send(12'd0, 12'd3, 13'd3, 1'b0);
        send(12'd2, 12'd2, 13'd6, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_drain_busy", 32'(busy), 32'd1);
        chk("t6_drain_done", 32'(done), 32'd0);
        wait_done("t6");
        chk_metrics("t6", 3, 2, 3, 2);
        do_start();
        chk("t6_restart_done", 32'(done), 32'd0);
        chk("t6_restart_busy", 32'(busy), 32'd1);
        chk("t6_restart_sat", 32'(sat), 32'd0);
        chk_metrics("t6_restart", 0, 0, 0, 0);
        send(12'd1, 12'd1, 13'd1, 1'b1);
        wait_done("t6b");
        chk_metrics("t6b", 1, 1, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
